// File: rtl/lisnoc_measure_sink.sv
// Ejection-side measurement endpoint: consumes every flit of one lisnoc link, tracks
// packet framing per virtual channel and accumulates packet/flit counts and latency stats.
module lisnoc_measure_sink #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 4,
  parameter int ts_width        = 32,
  parameter int cnt_width       = 32,
  parameter int sum_width       = 48
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [flit_type_width+flit_data_width-1:0] link_flit,
  input  logic [vchannels-1:0]                       link_valid,
  output logic [vchannels-1:0]                       link_ready,
  input  logic [ts_width-1:0]                        now,
  input  logic                                       stall,
  input  logic                                       clear,
  output logic [cnt_width-1:0]                       pkt_count,
  output logic [cnt_width-1:0]                       single_count,
  output logic [cnt_width-1:0]                       flit_count,
  output logic [sum_width-1:0]                       lat_sum,
  output logic [ts_width-1:0]                        lat_max,
  output logic                                       err_seq,
  output logic                                       err_multi
);

  localparam int VW = (vchannels > 1) ? $clog2(vchannels) : 1;

  localparam logic [1:0] T_PAYLOAD = 2'b00;
  localparam logic [1:0] T_HEADER  = 2'b01;
  localparam logic [1:0] T_LAST    = 2'b10;
  localparam logic [1:0] T_SINGLE  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_TS, BODY} state_t;

  state_t              state_q [vchannels];
  state_t              state_d [vchannels];
  logic [ts_width-1:0] ts_q    [vchannels];
  logic [ts_width-1:0] ts_d    [vchannels];

  logic [cnt_width-1:0] pkt_q, pkt_d, single_q, single_d, flit_q, flit_d;
  logic [sum_width-1:0] sum_q, sum_d;
  logic [ts_width-1:0]  max_q, max_d;
  logic                 err_seq_q, err_seq_d, err_multi_q, err_multi_d;

  logic [vchannels-1:0] acc;
  logic                 any_acc, multi;
  logic [VW-1:0]        vc_sel;
  logic [1:0]           ftype;
  logic [ts_width-1:0]  ts_in, done_ts, lat;
  logic                 ev_single, ev_done, ev_err;
  logic [sum_width:0]   sum_ext;

  // Ready is independent of reset so the link drains even while the sink is held in reset.
  assign link_ready = {vchannels{~stall}};
  assign ftype      = link_flit[flit_data_width +: 2];
  assign ts_in      = link_flit[ts_width-1:0];

  always_comb begin
    acc     = link_valid & link_ready;
    any_acc = |acc;
    multi   = |(acc & (acc - vchannels'(1)));
    vc_sel  = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (acc[v]) vc_sel = VW'(v);
    end
  end

  // Framing FSMs: only the addressed VC can move, and only on a clean single-valid transfer.
  always_comb begin
    for (int v = 0; v < vchannels; v++) begin
      state_d[v] = state_q[v];
      ts_d[v]    = ts_q[v];
    end
    ev_single = 1'b0;
    ev_done   = 1'b0;
    ev_err    = 1'b0;
    done_ts   = ts_q[vc_sel];
    if (any_acc && !multi) begin
      case (state_q[vc_sel])
        WAIT_TS, BODY: begin
          case (ftype)
            T_PAYLOAD: begin
              if (state_q[vc_sel] == WAIT_TS) begin
                ts_d[vc_sel]    = ts_in;
                state_d[vc_sel] = BODY;
              end
            end
            T_LAST: begin
              ev_done         = 1'b1;
              state_d[vc_sel] = IDLE;
              if (state_q[vc_sel] == WAIT_TS) begin
                ts_d[vc_sel] = ts_in;
                done_ts      = ts_in;
              end
            end
            T_HEADER: begin
              ev_err          = 1'b1;
              state_d[vc_sel] = WAIT_TS;
            end
            default: begin
              ev_err          = 1'b1;
              ev_single       = 1'b1;
              state_d[vc_sel] = IDLE;
            end
          endcase
        end
        default: begin
          state_d[vc_sel] = IDLE;
          case (ftype)
            T_HEADER: state_d[vc_sel] = WAIT_TS;
            T_SINGLE: ev_single       = 1'b1;
            default:  ev_err          = 1'b1;
          endcase
        end
      endcase
    end
  end

  assign lat     = now - done_ts;
  assign sum_ext = {1'b0, sum_q} + (sum_width+1)'(lat);

  always_comb begin
    pkt_d       = pkt_q;
    single_d    = single_q;
    flit_d      = flit_q;
    sum_d       = sum_q;
    max_d       = max_q;
    err_seq_d   = err_seq_q;
    err_multi_d = err_multi_q;
    if (any_acc && !(&flit_q)) flit_d = flit_q + cnt_width'(1);
    if (multi) err_multi_d = 1'b1;
    if (ev_err) err_seq_d = 1'b1;
    if (ev_single && !(&single_q)) single_d = single_q + cnt_width'(1);
    if (ev_done) begin
      if (!(&pkt_q)) pkt_d = pkt_q + cnt_width'(1);
      sum_d = sum_ext[sum_width] ? '1 : sum_ext[sum_width-1:0];
      if (lat > max_q) max_d = lat;
    end
    // Clear beats any event in the same cycle; framing state keeps running underneath.
    if (clear) begin
      pkt_d       = '0;
      single_d    = '0;
      flit_d      = '0;
      sum_d       = '0;
      max_d       = '0;
      err_seq_d   = 1'b0;
      err_multi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < vchannels; v++) begin
        state_q[v] <= IDLE;
        ts_q[v]    <= '0;
      end
      pkt_q       <= '0;
      single_q    <= '0;
      flit_q      <= '0;
      sum_q       <= '0;
      max_q       <= '0;
      err_seq_q   <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      for (int v = 0; v < vchannels; v++) begin
        state_q[v] <= state_d[v];
        ts_q[v]    <= ts_d[v];
      end
      pkt_q       <= pkt_d;
      single_q    <= single_d;
      flit_q      <= flit_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      err_seq_q   <= err_seq_d;
      err_multi_q <= err_multi_d;
    end
  end

  assign pkt_count    = pkt_q;
  assign single_count = single_q;
  assign flit_count   = flit_q;
  assign lat_sum      = sum_q;
  assign lat_max      = max_q;
  assign err_seq      = err_seq_q;
  assign err_multi    = err_multi_q;

endmodule

// File: tb/tb_lisnoc_measure_sink.sv
// Bench for lisnoc_measure_sink: directed scenarios plus random traffic against a
// packet-level reference model (per-VC open packet + first payload word).
module tb_lisnoc_measure_sink;

  localparam logic [1:0] PL = 2'b00, HD = 2'b01, LS = 2'b10, SG = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [33:0] link_flit = '0;
  logic [3:0]  link_valid = '0;
  logic [3:0]  link_ready;
  logic [31:0] now_r = '0;
  logic        stall = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pkt_count, single_count, flit_count, lat_max;
  logic [47:0] lat_sum;
  logic        err_seq, err_multi;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          m_open [4];
  bit          m_has_ts [4];
  logic [31:0] m_ts [4];
  longint      m_pkt, m_single, m_flit, m_sum;
  logic [31:0] m_max;
  bit          m_eseq, m_emulti;

  localparam longint CNT_MAX = 64'd4294967295;
  localparam longint SUM_MAX = 64'd281474976710655;

  always #5 clk = ~clk;

  lisnoc_measure_sink dut (
    .clk(clk), .rst(rst), .link_flit(link_flit), .link_valid(link_valid),
    .link_ready(link_ready), .now(now_r), .stall(stall), .clear(clear),
    .pkt_count(pkt_count), .single_count(single_count), .flit_count(flit_count),
    .lat_sum(lat_sum), .lat_max(lat_max), .err_seq(err_seq), .err_multi(err_multi)
  );

  function automatic void model_reset();
    for (int v = 0; v < 4; v++) begin
      m_open[v] = 0; m_has_ts[v] = 0; m_ts[v] = '0;
    end
    m_pkt = 0; m_single = 0; m_flit = 0; m_sum = 0; m_max = '0;
    m_eseq = 0; m_emulti = 0;
  endfunction

  // One clock edge of the link as seen by the model.
  function automatic void model_step(input logic [3:0] mask, input logic [1:0] t,
                                     input logic [31:0] d, input logic [31:0] nw,
                                     input bit clr);
    bit          got_single = 0, got_done = 0, got_err = 0, got_multi = 0;
    logic [31:0] lat = '0;
    int          vc = 0;
    if (mask != 0) begin
      if ($countones(mask) > 1) got_multi = 1;
      else begin
        for (int v = 0; v < 4; v++) if (mask[v]) vc = v;
        case (t)
          HD: begin
            if (m_open[vc]) got_err = 1;
            m_open[vc] = 1; m_has_ts[vc] = 0;
          end
          PL: begin
            if (!m_open[vc]) got_err = 1;
            else if (!m_has_ts[vc]) begin m_has_ts[vc] = 1; m_ts[vc] = d; end
          end
          LS: begin
            if (!m_open[vc]) got_err = 1;
            else begin
              if (!m_has_ts[vc]) m_ts[vc] = d;
              lat = nw - m_ts[vc];
              got_done = 1;
              m_open[vc] = 0;
            end
          end
          default: begin
            if (m_open[vc]) got_err = 1;
            m_open[vc] = 0;
            got_single = 1;
          end
        endcase
      end
    end
    if (clr) begin
      m_pkt = 0; m_single = 0; m_flit = 0; m_sum = 0; m_max = '0;
      m_eseq = 0; m_emulti = 0;
    end else begin
      if (mask != 0 && m_flit < CNT_MAX) m_flit++;
      if (got_multi) m_emulti = 1;
      if (got_err) m_eseq = 1;
      if (got_single && m_single < CNT_MAX) m_single++;
      if (got_done) begin
        if (m_pkt < CNT_MAX) m_pkt++;
        m_sum = m_sum + longint'(lat);
        if (m_sum > SUM_MAX) m_sum = SUM_MAX;
        if (lat > m_max) m_max = lat;
      end
    end
  endfunction

  task automatic send(input logic [3:0] mask, input logic [1:0] t, input logic [31:0] d,
                      input logic [31:0] nw, input bit clr);
    @(negedge clk);
    link_valid = mask;
    link_flit  = {t, d};
    now_r      = nw;
    clear      = clr;
    @(posedge clk);
    model_step(mask, t, d, nw, clr);
    #1;
    link_valid = '0;
    clear      = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #12 rst = 1'b0;
    send(4'b0001, HD, 32'h0, 32'd1, 0);
    send(4'b0001, PL, 32'd7, 32'd2, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (flit_count !== 32'd0 || pkt_count !== 32'd0 || lat_sum !== 48'd0 || err_seq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs flit=%0d pkt=%0d sum=%0d eseq=%0b required all 0",
               flit_count, pkt_count, lat_sum, err_seq);
    end
    checks++;
    if (link_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_ready got=%b required=1111", link_ready);
    end
    #2 rst = 1'b0;
    // the in-flight packet was lost, so its tail is a framing error
    send(4'b0001, LS, 32'd0, 32'd9, 0);
    checks++;
    if (err_seq !== m_eseq || pkt_count !== 32'(m_pkt)) begin
      failures++;
      $display("FAIL reset_fsm_idle err_seq=%0b pkt=%0d required err_seq=1 pkt=0", err_seq, pkt_count);
    end
    $display("test_reset: done");
    send(4'b0000, PL, 32'd0, 32'd0, 1);
  endtask

  task automatic test_basic();
    send(4'b0001, HD, 32'h0,   32'd100, 0);
    send(4'b0001, PL, 32'd100, 32'd110, 0);
    send(4'b0001, PL, 32'hABCD, 32'd120, 0);
    send(4'b0001, LS, 32'h1234, 32'd140, 0);
    checks++;
    if (pkt_count !== 32'd1 || flit_count !== 32'd4) begin
      failures++;
      $display("FAIL basic_counts pkt=%0d flit=%0d required pkt=1 flit=4", pkt_count, flit_count);
    end
    checks++;
    if (lat_sum !== 48'd40 || lat_max !== 32'd40) begin
      failures++;
      $display("FAIL basic_latency sum=%0d max=%0d required 40/40", lat_sum, lat_max);
    end
    $display("test_basic: pkt=%0d sum=%0d max=%0d", pkt_count, lat_sum, lat_max);
    send(4'b0000, PL, 32'd0, 32'd0, 1);
  endtask

  task automatic test_interleave();
    send(4'b0010, HD, 32'd0,  32'd0,  0);
    send(4'b0100, HD, 32'd0,  32'd1,  0);
    send(4'b0010, PL, 32'd10, 32'd2,  0);
    send(4'b0100, PL, 32'd5,  32'd3,  0);
    send(4'b0010, PL, 32'd77, 32'd4,  0);
    send(4'b0100, PL, 32'd88, 32'd5,  0);
    send(4'b0010, LS, 32'd99, 32'd30, 0);
    send(4'b0100, LS, 32'd66, 32'd50, 0);
    checks++;
    if (pkt_count !== 32'd2 || lat_sum !== 48'd65) begin
      failures++;
      $display("FAIL interleave_sum pkt=%0d sum=%0d required pkt=2 sum=65", pkt_count, lat_sum);
    end
    checks++;
    if (lat_max !== 32'd45 || err_seq !== 1'b0) begin
      failures++;
      $display("FAIL interleave_max max=%0d err_seq=%0b required max=45 err_seq=0", lat_max, err_seq);
    end
    $display("test_interleave: pkt=%0d sum=%0d max=%0d", pkt_count, lat_sum, lat_max);
    send(4'b0000, PL, 32'd0, 32'd0, 1);
  endtask

  task automatic test_wrap();
    send(4'b1000, HD, 32'd0,          32'hFFFF_FFE0, 0);
    send(4'b1000, LS, 32'hFFFF_FFF0, 32'h0000_0010, 0);
    checks++;
    if (lat_sum !== 48'd32 || lat_max !== 32'd32) begin
      failures++;
      $display("FAIL wrap_latency sum=%0d max=%0d required 32/32", lat_sum, lat_max);
    end
    send(4'b0001, SG, 32'h5, 32'd20, 0);
    checks++;
    if (single_count !== 32'd1 || pkt_count !== 32'd1) begin
      failures++;
      $display("FAIL wrap_single single=%0d pkt=%0d required 1/1", single_count, pkt_count);
    end
    $display("test_wrap: sum=%0d single=%0d", lat_sum, single_count);
    send(4'b0000, PL, 32'd0, 32'd0, 1);
  endtask

  task automatic test_errors();
    send(4'b1000, PL, 32'd3, 32'd1, 0);
    checks++;
    if (err_seq !== 1'b1 || err_multi !== 1'b0) begin
      failures++;
      $display("FAIL err_seq_set eseq=%0b emulti=%0b required 1/0", err_seq, err_multi);
    end
    send(4'b0011, HD, 32'd0, 32'd2, 0);
    checks++;
    if (err_multi !== 1'b1 || flit_count !== 32'd2) begin
      failures++;
      $display("FAIL err_multi_set emulti=%0b flit=%0d required 1/2", err_multi, flit_count);
    end
    // the multi-valid header must not have opened a packet on VC0 or VC1
    send(4'b0001, LS, 32'd0, 32'd3, 1);
    checks++;
    if (err_seq !== 1'b0 || err_multi !== 1'b0 || flit_count !== 32'd0) begin
      failures++;
      $display("FAIL err_clear eseq=%0b emulti=%0b flit=%0d required 0/0/0", err_seq, err_multi, flit_count);
    end
    send(4'b0001, HD, 32'd0,  32'd10, 0);
    send(4'b0001, PL, 32'd10, 32'd11, 0);
    send(4'b0001, LS, 32'd0,  32'd20, 1);
    checks++;
    if (pkt_count !== 32'd0 || lat_sum !== 48'd0 || flit_count !== 32'd0) begin
      failures++;
      $display("FAIL clear_vs_tail pkt=%0d sum=%0d flit=%0d required 0/0/0", pkt_count, lat_sum, flit_count);
    end
    send(4'b0001, SG, 32'd0, 32'd21, 0);
    checks++;
    if (err_seq !== m_eseq || single_count !== 32'(m_single)) begin
      failures++;
      $display("FAIL clear_fsm_idle eseq=%0b single=%0d required %0b/%0d", err_seq, single_count, m_eseq, m_single);
    end
    $display("test_errors: done");
    send(4'b0000, PL, 32'd0, 32'd0, 1);
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall      = 1'b1;
    link_valid = 4'b0100;
    link_flit  = {SG, 32'h0};
    now_r      = 32'd500;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link_ready !== 4'b0000 || flit_count !== 32'(m_flit)) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d ready=%b flit=%0d required 0000/%0d", i, link_ready, flit_count, m_flit);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    model_step(4'b0100, SG, 32'h0, 32'd500, 0);
    #1;
    link_valid = '0;
    @(posedge clk);
    #1;
    checks++;
    if (flit_count !== 32'(m_flit) || single_count !== 32'(m_single)) begin
      failures++;
      $display("FAIL stall_release flit=%0d single=%0d required %0d/%0d", flit_count, single_count, m_flit, m_single);
    end
    $display("test_stall: flit=%0d single=%0d", flit_count, single_count);
  endtask

  task automatic test_random();
    logic [3:0]  mask;
    logic [1:0]  t;
    logic [31:0] d, nw;
    bit          clr;
    int          bad = 0;
    nw = 32'hFFFF_F000;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(99);
      if (r < 88)      mask = 4'b0001 << $urandom_range(3);
      else if (r < 94) mask = 4'b0011 << $urandom_range(2);
      else             mask = 4'b0000;
      t   = 2'($urandom_range(3));
      nw  = nw + 32'($urandom_range(40, 1));
      d   = nw - 32'($urandom_range(500));
      clr = ($urandom_range(99) < 3);
      send(mask, t, d, nw, clr);
      checks++;
      if (pkt_count !== 32'(m_pkt) || single_count !== 32'(m_single) || flit_count !== 32'(m_flit) ||
          lat_sum !== 48'(m_sum) || lat_max !== m_max || err_seq !== m_eseq || err_multi !== m_emulti) begin
        failures++;
        bad++;
        $display("FAIL random_step i=%0d pkt=%0d/%0d single=%0d/%0d flit=%0d/%0d sum=%0d/%0d max=%0d/%0d eseq=%0b/%0b emulti=%0b/%0b (got/required)",
                 i, pkt_count, m_pkt, single_count, m_single, flit_count, m_flit, lat_sum, m_sum,
                 lat_max, m_max, err_seq, m_eseq, err_multi, m_emulti);
      end
    end
    $display("test_random: 400 steps, pkt=%0d single=%0d flit=%0d bad=%0d", pkt_count, single_count, flit_count, bad);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_wrap();
    test_errors();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
